// File: rtl/puf_crp_sequencer_pkg.sv
// puf_crp_sequencer_pkg
//   Shared definitions for the PUF challenge-response sequencer:
//   the 3-bit FSM state encoding, default challenge/response widths
//   and the width of the per-bit vote accumulators.
//   No ports (package).
package puf_crp_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_RELAX   = 3'd3,
    ST_VOTE    = 3'd4,
    ST_SEND    = 3'd5,
    ST_WAIT_TX = 3'd6
  } state_t;

  localparam int CW_DEFAULT = 16;
  localparam int RW_DEFAULT = 16;

  // Four bits hold counts up to 15, enough for the largest legal NEVAL.
  localparam int ACC_W = 4;

endpackage

// File: rtl/puf_crp_sequencer_majority_vote_acc.sv
// puf_crp_sequencer_majority_vote_acc
//   One ACC_W-bit counter per response bit. Counts how many evaluations
//   returned a 1 for that bit and produces a combinational majority vote.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_clr           zero all accumulators (wins over i_add)
//     i_add           add i_bits into the accumulators this cycle
//     i_bits          RW sampled PUF response bits
//     o_vote          bit i is 1 when 2*acc[i] > NEVAL
module puf_crp_sequencer_majority_vote_acc
  import puf_crp_sequencer_pkg::*;
#(
  parameter int RW    = RW_DEFAULT,
  parameter int NEVAL = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_add,
  input  logic [RW-1:0] i_bits,
  output logic [RW-1:0] o_vote
);

  localparam int VW = ACC_W + 1;

  logic [ACC_W-1:0] r_acc [RW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RW; i++) r_acc[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < RW; i++) r_acc[i] <= '0;
    end else if (i_add) begin
      for (int i = 0; i < RW; i++) r_acc[i] <= r_acc[i] + ACC_W'(i_bits[i]);
    end
  end

  // Doubling the count avoids a division: majority means 2*acc > NEVAL.
  always_comb begin
    o_vote = '0;
    for (int i = 0; i < RW; i++) begin
      o_vote[i] = ({r_acc[i], 1'b0} > VW'(NEVAL));
    end
  end

endmodule

// File: rtl/puf_crp_sequencer.sv
// puf_crp_sequencer
//   Sequences one challenge-response transaction of the arbiter PUF:
//   latch challenge, run NEVAL timed evaluations (SETTLE cycles enabled,
//   one sample cycle, RELAX cycles disabled between them), majority-vote
//   the response bits, hand the word to the UART transmitter and wait.
//   Ports:
//     i_clk, i_rst_n    clock, asynchronous active-low reset
//     i_ch_valid        one-cycle pulse, i_ch_data valid
//     i_ch_data         Gray-coded challenge word
//     o_puf_challenge   registered challenge driven into the PUF
//     o_puf_en          PUF launch/enable
//     i_puf_response    arbiter outputs
//     o_tx_data         voted response word
//     o_tx_start        one-cycle transmit request
//     i_tx_done         one-cycle transmit completion
//     o_busy            high whenever the FSM is not idle
//     o_overrun         sticky: a challenge was dropped
//     i_clr_overrun     clears o_overrun (a simultaneous drop wins)
//     o_crp_count       completed transactions, wraps to zero
module puf_crp_sequencer
  import puf_crp_sequencer_pkg::*;
#(
  parameter int CW     = CW_DEFAULT,
  parameter int RW     = RW_DEFAULT,
  parameter int NEVAL  = 5,
  parameter int SETTLE = 8,
  parameter int RELAX  = 4,
  parameter int CRP_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ch_valid,
  input  logic [CW-1:0]    i_ch_data,
  output logic [CW-1:0]    o_puf_challenge,
  output logic             o_puf_en,
  input  logic [RW-1:0]    i_puf_response,
  output logic [RW-1:0]    o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  output logic             o_busy,
  output logic             o_overrun,
  input  logic             i_clr_overrun,
  output logic [CRP_W-1:0] o_crp_count
);

  localparam int PMAX = (SETTLE > RELAX) ? SETTLE : RELAX;
  localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX);

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [ACC_W-1:0] r_eval_cnt;
  logic [CW-1:0]    r_puf_challenge;
  logic             r_puf_en;
  logic [RW-1:0]    r_tx_data;
  logic             r_tx_start;
  logic             r_busy;
  logic             r_overrun;
  logic [CRP_W-1:0] r_crp_count;

  logic             w_accept;
  logic             w_drop;
  logic             w_acc_add;
  logic [RW-1:0]    w_vote;

  assign w_accept  = (r_state == ST_IDLE) && i_ch_valid;
  assign w_drop    = (r_state != ST_IDLE) && i_ch_valid;
  assign w_acc_add = (r_state == ST_SAMPLE);

  puf_crp_sequencer_majority_vote_acc #(
    .RW    (RW),
    .NEVAL (NEVAL)
  ) u_vote (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .i_add   (w_acc_add),
    .i_bits  (i_puf_response),
    .o_vote  (w_vote)
  );

  // r_phase counts cycles inside EVAL and RELAX; it is zeroed on every
  // entry so each phase lasts exactly SETTLE or RELAX cycles. Outputs are
  // registered alongside the state so they line up with it cycle for cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_phase         <= '0;
      r_eval_cnt      <= '0;
      r_puf_challenge <= '0;
      r_puf_en        <= 1'b0;
      r_tx_data       <= '0;
      r_tx_start      <= 1'b0;
      r_busy          <= 1'b0;
      r_overrun       <= 1'b0;
      r_crp_count     <= '0;
    end else begin
      r_tx_start <= 1'b0;

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_ch_valid) begin
            r_puf_challenge <= i_ch_data;
            r_eval_cnt      <= '0;
            r_phase         <= '0;
            r_puf_en        <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (r_phase == PW'(SETTLE - 1)) begin
            r_phase <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        ST_SAMPLE: begin
          r_eval_cnt <= r_eval_cnt + ACC_W'(1);
          r_puf_en   <= 1'b0;
          r_phase    <= '0;
          if (r_eval_cnt == ACC_W'(NEVAL - 1)) begin
            r_state <= ST_VOTE;
          end else begin
            r_state <= ST_RELAX;
          end
        end
        ST_RELAX: begin
          if (r_phase == PW'(RELAX - 1)) begin
            r_phase  <= '0;
            r_puf_en <= 1'b1;
            r_state  <= ST_EVAL;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        ST_VOTE: begin
          r_tx_data  <= w_vote;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            r_crp_count <= r_crp_count + CRP_W'(1);
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_puf_en <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_puf_challenge = r_puf_challenge;
  assign o_puf_en        = r_puf_en;
  assign o_tx_data       = r_tx_data;
  assign o_tx_start      = r_tx_start;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;
  assign o_crp_count     = r_crp_count;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// tb_puf_crp_sequencer
//   Directed bench for puf_crp_sequencer. dutA uses the default timing
//   (NEVAL=5, SETTLE=8, RELAX=4); dutB uses NEVAL=1, SETTLE=2, RELAX=1 and
//   a 4-bit transaction counter so the wrap can be reached quickly.
//   Cycle 0 is the cycle in which ch_valid is presented.
module tb_puf_crp_sequencer;

  typedef logic [4:0][15:0] pat_t;

  logic        clk;
  logic        rstN;

  logic        aChValid, aTxDone, aClrOverrun;
  logic [15:0] aChData, aPufResp;
  logic [15:0] aPufChal, aTxData, aCrpCount;
  logic        aPufEn, aTxStart, aBusy, aOverrun;

  logic        bChValid, bTxDone, bClrOverrun;
  logic [15:0] bChData, bPufResp;
  logic [15:0] bPufChal, bTxData;
  logic [3:0]  bCrpCount;
  logic        bPufEn, bTxStart, bBusy, bOverrun;

  int          checks;
  int          errors;
  logic [15:0] expCrpA;
  logic [3:0]  expCrpB;

  puf_crp_sequencer dutA (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_ch_valid      (aChValid),
    .i_ch_data       (aChData),
    .o_puf_challenge (aPufChal),
    .o_puf_en        (aPufEn),
    .i_puf_response  (aPufResp),
    .o_tx_data       (aTxData),
    .o_tx_start      (aTxStart),
    .i_tx_done       (aTxDone),
    .o_busy          (aBusy),
    .o_overrun       (aOverrun),
    .i_clr_overrun   (aClrOverrun),
    .o_crp_count     (aCrpCount)
  );

  puf_crp_sequencer #(
    .NEVAL  (1),
    .SETTLE (2),
    .RELAX  (1),
    .CRP_W  (4)
  ) dutB (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_ch_valid      (bChValid),
    .i_ch_data       (bChData),
    .o_puf_challenge (bPufChal),
    .o_puf_en        (bPufEn),
    .i_puf_response  (bPufResp),
    .o_tx_data       (bTxData),
    .o_tx_start      (bTxStart),
    .i_tx_done       (bTxDone),
    .o_busy          (bBusy),
    .o_overrun       (bOverrun),
    .i_clr_overrun   (bClrOverrun),
    .o_crp_count     (bCrpCount)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic pat_t mk5(input logic [15:0] p0, input logic [15:0] p1,
                               input logic [15:0] p2, input logic [15:0] p3,
                               input logic [15:0] p4);
    pat_t p;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3; p[4] = p4;
    return p;
  endfunction

  // One full default-timing transaction on dutA. Sample k uses pats[k-1];
  // puf_en is expected high in cycles 1-9, 14-22, ..., 53-61 and tx_start
  // only in cycle 63. tx_done is pulsed at cycle 5 (must be ignored) and at
  // cycle 70 (must complete). Optional overrun probing around dropAt.
  task automatic applyStimulus(input logic [15:0] ch, input pat_t pats,
                               input logic [15:0] expTx, input int dropAt,
                               input bit dropOnDone);
    aChData  = ch;
    aChValid = 1'b1;
    aPufResp = pats[0];
    tick();
    aChValid = 1'b0;
    checkOutput("busyRise", aBusy, 1);
    for (int c = 1; c <= 63; c++) begin
      aPufResp = pats[(c - 1) / 13];
      checkOutput($sformatf("pufEn c%0d", c), aPufEn, (c <= 61) && (((c - 1) % 13) < 9));
      checkOutput($sformatf("txStart c%0d", c), aTxStart, c == 63);
      if (c == 5) aTxDone = 1'b1;
      if (c == 6) aTxDone = 1'b0;
      if (dropAt > 0) begin
        if (c == dropAt) begin
          checkOutput("overrunPre", aOverrun, 0);
          aChValid = 1'b1;
          aChData  = 16'hBEEF;
        end
        if (c == dropAt + 1) begin
          checkOutput("overrunSet", aOverrun, 1);
          checkOutput("chalKept", aPufChal, ch);
          aChValid = 1'b0;
        end
        if (c == dropAt + 2) begin
          aChValid    = 1'b1;
          aClrOverrun = 1'b1;
        end
        if (c == dropAt + 3) begin
          checkOutput("overrunSetWins", aOverrun, 1);
          aChValid    = 1'b0;
          aClrOverrun = 1'b1;
        end
        if (c == dropAt + 4) begin
          checkOutput("overrunClr", aOverrun, 0);
          aClrOverrun = 1'b0;
        end
      end
      if (c < 63) tick();
    end
    checkOutput("txData", aTxData, expTx);
    checkOutput("pufChal", aPufChal, ch);
    for (int c = 64; c <= 70; c++) begin
      tick();
      if (c == 64) checkOutput("txStartLow", aTxStart, 0);
    end
    checkOutput("txDataHold", aTxData, expTx);
    checkOutput("busyWait", aBusy, 1);
    aTxDone = 1'b1;
    if (dropOnDone) begin
      aChValid = 1'b1;
      aChData  = 16'hDEAD;
    end
    tick();
    aTxDone  = 1'b0;
    aChValid = 1'b0;
    expCrpA  = expCrpA + 16'd1;
    checkOutput("busyFall", aBusy, 0);
    checkOutput("crpCount", aCrpCount, expCrpA);
    if (dropOnDone) begin
      checkOutput("overrunOnDone", aOverrun, 1);
      checkOutput("chalAfterDone", aPufChal, ch);
      aClrOverrun = 1'b1;
      tick();
      aClrOverrun = 1'b0;
      checkOutput("overrunClr2", aOverrun, 0);
    end
  endtask

  // One NEVAL=1/SETTLE=2 transaction on dutB: tx_start expected at cycle 5,
  // tx_done returned at cycle 6, idle again at cycle 7.
  task automatic applyStimulusFast(input logic [15:0] ch, input logic [15:0] resp,
                                   input logic [15:0] expTx);
    bChData  = ch;
    bChValid = 1'b1;
    bPufResp = resp;
    tick();
    bChValid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("txStartB c%0d", c), bTxStart, c == 5);
      if (c < 5) tick();
    end
    checkOutput("txDataB", bTxData, expTx);
    tick();
    bTxDone = 1'b1;
    tick();
    bTxDone = 1'b0;
    expCrpB = expCrpB + 4'd1;
    checkOutput("busyFallB", bBusy, 0);
    checkOutput("crpCountB", bCrpCount, expCrpB);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    expCrpA     = '0;
    expCrpB     = '0;
    rstN        = 1'b0;
    aChValid    = 1'b0; aChData  = '0; aPufResp = '0;
    aTxDone     = 1'b0; aClrOverrun = 1'b0;
    bChValid    = 1'b0; bChData  = '0; bPufResp = '0;
    bTxDone     = 1'b0; bClrOverrun = 1'b0;

    // Reset values.
    tick();
    tick();
    checkOutput("rstPufEn", aPufEn, 0);
    checkOutput("rstTxStart", aTxStart, 0);
    checkOutput("rstBusy", aBusy, 0);
    checkOutput("rstOverrun", aOverrun, 0);
    checkOutput("rstCrp", aCrpCount, 0);
    checkOutput("rstChal", aPufChal, 0);
    checkOutput("rstTxData", aTxData, 0);
    checkOutput("rstCrpB", bCrpCount, 0);
    #3 rstN = 1'b1;
    tick();

    // Reset in the middle of the second EVAL phase (cycle 20).
    aChData  = 16'h5555;
    aChValid = 1'b1;
    aPufResp = 16'hFFFF;
    tick();
    aChValid = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    checkOutput("busyMidEval", aBusy, 1);
    checkOutput("pufEnMidEval", aPufEn, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstPufEn", aPufEn, 0);
    checkOutput("midRstBusy", aBusy, 0);
    checkOutput("midRstChal", aPufChal, 0);
    checkOutput("midRstTxData", aTxData, 0);
    tick();
    tick();
    #3 rstN = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (aTxStart !== 1'b0) checkOutput("noTxStartAfterRst", aTxStart, 0);
    end
    checkOutput("rstTxStartIdle", aTxStart, 0);
    checkOutput("rstCrpKept", aCrpCount, 0);
    checkOutput("rstBusyIdle", aBusy, 0);

    // Normal transaction after reset.
    applyStimulus(16'h1234, mk5(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F),
                  16'h0F0F, 0, 1'b0);

    // Stable response.
    applyStimulus(16'hA5A5, mk5(16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C),
                  16'h3C3C, 0, 1'b0);

    // Noisy responses: each bit 3 of 5 ones, then each bit 2 of 5 ones.
    applyStimulus(16'h0001, mk5(16'hFFFF, 16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00),
                  16'hFFFF, 0, 1'b0);
    applyStimulus(16'h0002, mk5(16'hFFFF, 16'h0000, 16'h0000, 16'h00FF, 16'hFF00),
                  16'h0000, 0, 1'b0);

    // Overrun handling: drop at cycle 30, drop at tx_done.
    applyStimulus(16'hC3D2, mk5(16'h6C93, 16'h6C93, 16'h0000, 16'h6C93, 16'hFFFF),
                  16'h6C93, 30, 1'b1);

    // Short configuration and counter wrap (4-bit counter: 16 transactions).
    for (int i = 0; i < 16; i++) begin
      applyStimulusFast(16'h0100 + 16'(i), 16'hA0A0 ^ 16'(i), 16'hA0A0 ^ 16'(i));
      if (i == 14) checkOutput("crpBeforeWrap", bCrpCount, 4'hF);
    end
    checkOutput("crpWrapped", bCrpCount, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
